// File: rtl/mips_mc_pkg.sv
// Shared encodings for the multicycle MIPS control unit: FSM states, ALU codes,
// opcode/funct values and datapath mux selects.
package mips_mc_pkg;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_RTEXE  = 4'd6,
        S_RTWB   = 4'd7,
        S_IMMEXE = 4'd8,
        S_IMMWB  = 4'd9,
        S_BRANCH = 4'd10,
        S_JUMP   = 4'd11,
        S_JAL    = 4'd12,
        S_JR     = 4'd13,
        S_HALT   = 4'd14,
        S_BAD    = 4'd15
    } state_e;

    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_SLT  = 4'b0111;
    localparam logic [3:0] ALU_SLTU = 4'b1111;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_SLTIU = 6'b001011;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] F_JR   = 6'b001000;
    localparam logic [5:0] F_ADD  = 6'b100000;
    localparam logic [5:0] F_ADDU = 6'b100001;
    localparam logic [5:0] F_SUB  = 6'b100010;
    localparam logic [5:0] F_SUBU = 6'b100011;
    localparam logic [5:0] F_AND  = 6'b100100;
    localparam logic [5:0] F_OR   = 6'b100101;
    localparam logic [5:0] F_SLT  = 6'b101010;
    localparam logic [5:0] F_SLTU = 6'b101011;

    localparam logic [1:0] PCSRC_ALU    = 2'd0;
    localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
    localparam logic [1:0] PCSRC_JUMP   = 2'd2;
    localparam logic [1:0] PCSRC_REG    = 2'd3;

    localparam logic [1:0] SRCB_B     = 2'd0;
    localparam logic [1:0] SRCB_FOUR  = 2'd1;
    localparam logic [1:0] SRCB_IMM   = 2'd2;
    localparam logic [1:0] SRCB_IMMSH = 2'd3;

    localparam logic [1:0] REGDST_RT = 2'd0;
    localparam logic [1:0] REGDST_RD = 2'd1;
    localparam logic [1:0] REGDST_RA = 2'd2;

    localparam logic [1:0] M2R_ALUOUT = 2'd0;
    localparam logic [1:0] M2R_MDR    = 2'd1;
    localparam logic [1:0] M2R_PC     = 2'd2;

    function automatic logic is_imm_op(input logic [5:0] op);
        return (op == OP_ADDI) || (op == OP_ADDIU) || (op == OP_SLTI) ||
               (op == OP_SLTIU) || (op == OP_ORI) || (op == OP_LUI);
    endfunction

endpackage

// File: rtl/mips_mc_aludec.sv
// ALU decoder: maps R-type funct or immediate opcode to an ALU control code and
// flags encodings the datapath cannot execute.
module mips_mc_aludec
    import mips_mc_pkg::*;
(
    input  logic [5:0] op_i,
    input  logic [5:0] funct_i,
    output logic [3:0] alucontrol_o,
    output logic       valid_o
);

    // NOTE: every output gets a default before the case so no path can infer a latch.
    always_comb begin
        alucontrol_o = ALU_ADD;
        valid_o      = 1'b1;
        if (op_i == OP_RTYPE) begin
            case (funct_i)
                F_ADD, F_ADDU: alucontrol_o = ALU_ADD;
                F_SUB, F_SUBU: alucontrol_o = ALU_SUB;
                F_AND:         alucontrol_o = ALU_AND;
                F_OR:          alucontrol_o = ALU_OR;
                F_SLT:         alucontrol_o = ALU_SLT;
                F_SLTU:        alucontrol_o = ALU_SLTU;
                default:       valid_o      = 1'b0;
            endcase
        end else begin
            case (op_i)
                OP_ADDI, OP_ADDIU, OP_LUI: alucontrol_o = ALU_ADD;
                OP_SLTI:  alucontrol_o = ALU_SLT;
                OP_SLTIU: alucontrol_o = ALU_SLTU;
                OP_ORI:   alucontrol_o = ALU_OR;
                default:  valid_o      = 1'b0;
            endcase
        end
    end

endmodule

// File: rtl/mips_mc_ctrl.sv
// Multicycle MIPS control FSM: Moore state decode with strobes qualified by
// mem_ready/zero, a retired-instruction counter and a sticky illegal-op halt.
module mips_mc_ctrl
    import mips_mc_pkg::*;
#(
    parameter bit STALL_EN = 1'b1,
    parameter int CNT_W    = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       op,
    input  logic [5:0]       funct,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             iord,
    output logic             memread,
    output logic             memwrite,
    output logic             irwrite,
    output logic             regwrite,
    output logic [1:0]       regdst,
    output logic [1:0]       memtoreg,
    output logic             alusrca,
    output logic [1:0]       alusrcb,
    output logic             signext,
    output logic             shiftl16,
    output logic [3:0]       alucontrol,
    output logic [1:0]       pcsrc,
    output logic             pcen,
    output logic             retire,
    output logic [CNT_W-1:0] instret,
    output logic             halted,
    output logic [3:0]       state
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_e           state_q, state_d;
    logic [CNT_W-1:0] instret_q;
    logic             halted_q;
    logic             ready;
    logic [3:0]       dec_alu;
    logic             dec_valid;
    logic             memread_raw, memwrite_raw, irwrite_raw, regwrite_raw, pcen_raw, retire_raw;

    assign ready = STALL_EN ? mem_ready : 1'b1;

    mips_mc_aludec u_aludec (
        .op_i         (op),
        .funct_i      (funct),
        .alucontrol_o (dec_alu),
        .valid_o      (dec_valid)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:  if (ready) state_d = S_DECODE;
            S_DECODE: begin
                if (op == OP_RTYPE)
                    state_d = (funct == F_JR) ? S_JR : (dec_valid ? S_RTEXE : S_HALT);
                else if (op == OP_LW || op == OP_SW)   state_d = S_MEMADR;
                else if (op == OP_BEQ || op == OP_BNE) state_d = S_BRANCH;
                else if (is_imm_op(op))                state_d = S_IMMEXE;
                else if (op == OP_J)                   state_d = S_JUMP;
                else if (op == OP_JAL)                 state_d = S_JAL;
                else                                   state_d = S_HALT;
            end
            S_MEMADR: state_d = (op == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:  if (ready) state_d = S_MEMWB;
            S_MEMWR:  if (ready) state_d = S_FETCH;
            S_RTEXE:  state_d = S_RTWB;
            S_IMMEXE: state_d = S_IMMWB;
            S_MEMWB, S_RTWB, S_IMMWB, S_BRANCH, S_JUMP, S_JAL, S_JR: state_d = S_FETCH;
            default:  state_d = S_HALT;
        endcase
    end

    always_comb begin
        iord         = 1'b0;
        memread_raw  = 1'b0;
        memwrite_raw = 1'b0;
        irwrite_raw  = 1'b0;
        regwrite_raw = 1'b0;
        pcen_raw     = 1'b0;
        retire_raw   = 1'b0;
        regdst       = REGDST_RT;
        memtoreg     = M2R_ALUOUT;
        alusrca      = 1'b0;
        alusrcb      = SRCB_B;
        signext      = 1'b0;
        shiftl16     = 1'b0;
        alucontrol   = ALU_ADD;
        pcsrc        = PCSRC_ALU;
        case (state_q)
            S_FETCH: begin
                memread_raw = 1'b1;
                alusrcb     = SRCB_FOUR;
                irwrite_raw = ready;
                pcen_raw    = ready;
            end
            S_DECODE: begin
                alusrcb = SRCB_IMMSH;
                signext = 1'b1;
            end
            S_MEMADR: begin
                alusrca = 1'b1;
                alusrcb = SRCB_IMM;
                signext = 1'b1;
            end
            S_MEMRD: begin
                memread_raw = 1'b1;
                iord        = 1'b1;
            end
            S_MEMWB: begin
                regwrite_raw = 1'b1;
                memtoreg     = M2R_MDR;
                retire_raw   = 1'b1;
            end
            S_MEMWR: begin
                memwrite_raw = 1'b1;
                iord         = 1'b1;
                retire_raw   = ready;
            end
            S_RTEXE: begin
                alusrca    = 1'b1;
                alucontrol = dec_alu;
            end
            S_RTWB: begin
                regwrite_raw = 1'b1;
                regdst       = REGDST_RD;
                retire_raw   = 1'b1;
            end
            // Writeback repeats the execute selects so the ALU result stays valid.
            S_IMMEXE, S_IMMWB: begin
                alusrca      = 1'b1;
                alusrcb      = SRCB_IMM;
                signext      = (op != OP_ORI) && (op != OP_LUI);
                shiftl16     = (op == OP_LUI);
                alucontrol   = dec_alu;
                regwrite_raw = (state_q == S_IMMWB);
                retire_raw   = (state_q == S_IMMWB);
            end
            S_BRANCH: begin
                alusrca    = 1'b1;
                alucontrol = ALU_SUB;
                pcsrc      = PCSRC_ALUOUT;
                pcen_raw   = (op == OP_BNE) ? ~zero : zero;
                retire_raw = 1'b1;
            end
            S_JUMP, S_JAL: begin
                pcsrc        = PCSRC_JUMP;
                pcen_raw     = 1'b1;
                retire_raw   = 1'b1;
                regwrite_raw = (state_q == S_JAL);
                regdst       = (state_q == S_JAL) ? REGDST_RA : REGDST_RT;
                memtoreg     = (state_q == S_JAL) ? M2R_PC : M2R_ALUOUT;
            end
            S_JR: begin
                pcsrc      = PCSRC_REG;
                pcen_raw   = 1'b1;
                retire_raw = 1'b1;
            end
            default: ;
        endcase
    end

    // NOTE: strobes are masked by reset combinationally so they drop the moment
    // reset rises, not at the next clock edge.
    assign memread  = memread_raw  & ~reset;
    assign memwrite = memwrite_raw & ~reset;
    assign irwrite  = irwrite_raw  & ~reset;
    assign regwrite = regwrite_raw & ~reset;
    assign pcen     = pcen_raw     & ~reset;
    assign retire   = retire_raw   & ~reset;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_FETCH;
            instret_q <= '0;
            halted_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (retire_raw) instret_q <= instret_q + CNT_ONE;
            if (state_d == S_HALT) halted_q <= 1'b1;
        end
    end

    assign instret = instret_q;
    assign halted  = halted_q;
    assign state   = state_q;

endmodule

// File: tb/tb_mips_mc_ctrl.sv
// Self-checking bench for mips_mc_ctrl: table of instruction vectors checked via
// a retire-driven scoreboard, plus hand sequences for stalls, halt and reset.
module tb_mips_mc_ctrl;
    import mips_mc_pkg::*;

    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic [5:0]       op, funct;
    logic             zero, mem_ready;
    logic             iord, memread, memwrite, irwrite, regwrite;
    logic [1:0]       regdst, memtoreg, alusrcb, pcsrc;
    logic             alusrca, signext, shiftl16, pcen, retire, halted;
    logic [3:0]       alucontrol, state;
    logic [CNT_W-1:0] instret;

    mips_mc_ctrl #(.STALL_EN(1'b1), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
        .mem_ready(mem_ready), .iord(iord), .memread(memread), .memwrite(memwrite),
        .irwrite(irwrite), .regwrite(regwrite), .regdst(regdst), .memtoreg(memtoreg),
        .alusrca(alusrca), .alusrcb(alusrcb), .signext(signext), .shiftl16(shiftl16),
        .alucontrol(alucontrol), .pcsrc(pcsrc), .pcen(pcen), .retire(retire),
        .instret(instret), .halted(halted), .state(state)
    );

    always #5 clk = ~clk;

    typedef struct {
        string           name;
        logic [5:0]      op;
        logic [5:0]      funct;
        logic            zero;
        int              n;
        logic [4:0][3:0] seq;
        logic [3:0]      alu2;
        logic            fin_pcen;
        logic [1:0]      fin_pcsrc;
        logic            fin_rw;
        logic [1:0]      fin_rd;
        logic [1:0]      fin_m2r;
        logic [3:0]      fin_alu;
        logic [1:0]      fin_ext;
        logic            fin_mw;
    } vec_t;

    typedef struct {
        vec_t             v;
        logic [CNT_W-1:0] instret;
    } sb_t;

    vec_t             vecs[$];
    sb_t              sb_q[$];
    vec_t             j_vec;
    logic [CNT_W-1:0] exp_instret;
    int               n_checks = 0;
    int               n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    function automatic vec_t mk(input string name, input logic [5:0] o, input logic [5:0] f,
                                input logic z, input int n, input logic [3:0] s2,
                                input logic [3:0] s3, input logic [3:0] s4, input logic [3:0] alu2,
                                input logic pe, input logic [1:0] ps, input logic rw,
                                input logic [1:0] rd, input logic [1:0] m2r, input logic [3:0] falu,
                                input logic [1:0] ext, input logic mw);
        vec_t v;
        v.name = name; v.op = o; v.funct = f; v.zero = z; v.n = n;
        v.seq[0] = 4'd0; v.seq[1] = 4'd1; v.seq[2] = s2; v.seq[3] = s3; v.seq[4] = s4;
        v.alu2 = alu2; v.fin_pcen = pe; v.fin_pcsrc = ps; v.fin_rw = rw; v.fin_rd = rd;
        v.fin_m2r = m2r; v.fin_alu = falu; v.fin_ext = ext; v.fin_mw = mw;
        return v;
    endfunction

    // Drives one instruction from FETCH with zero wait states; entered on a negedge.
    task automatic run_vec(input vec_t v);
        sb_t item;
        bit  done;
        op = v.op; funct = v.funct; zero = v.zero; mem_ready = 1'b1;
        item.v = v; item.instret = exp_instret;
        sb_q.push_back(item);
        done = 1'b0;
        for (int k = 0; k < 12 && !done; k++) begin
            #1;
            if (k < v.n) check({v.name, " state"}, 32'(state), 32'(v.seq[k]));
            if (k == 0) check({v.name, " fetch strobes"},
                              32'({memread, irwrite, pcen, iord, alusrca, alusrcb}), 32'(7'b1110001));
            if (k == 2) check({v.name, " exe alu"}, 32'(alucontrol), 32'(v.alu2));
            if (retire) begin
                item = sb_q.pop_front();
                check({item.v.name, " latency"}, k + 1, item.v.n);
                check({item.v.name, " pcen"}, 32'(pcen), 32'(item.v.fin_pcen));
                check({item.v.name, " pcsrc"}, 32'(pcsrc), 32'(item.v.fin_pcsrc));
                check({item.v.name, " regwrite"}, 32'(regwrite), 32'(item.v.fin_rw));
                check({item.v.name, " regdst"}, 32'(regdst), 32'(item.v.fin_rd));
                check({item.v.name, " memtoreg"}, 32'(memtoreg), 32'(item.v.fin_m2r));
                check({item.v.name, " wb alu"}, 32'(alucontrol), 32'(item.v.fin_alu));
                check({item.v.name, " ext"}, 32'({signext, shiftl16}), 32'(item.v.fin_ext));
                check({item.v.name, " memwrite"}, 32'(memwrite), 32'(item.v.fin_mw));
                check({item.v.name, " instret"}, 32'(instret), 32'(item.instret));
                exp_instret++;
                done = 1'b1;
            end
            @(negedge clk);
        end
        if (!done) check({v.name, " retire timeout"}, 32'(0), 32'(1));
    endtask

    task automatic lw_stall();
        int  irw = 0, mr_bad = 0, mr_cyc = 0, cycles = 0;
        bit  done = 1'b0;
        op = OP_LW; funct = 6'd0; zero = 1'b0;
        for (int k = 0; k < 20 && !done; k++) begin
            mem_ready = !(k == 0 || k == 1 || k == 5 || k == 6);
            #1;
            if (irwrite) irw++;
            if (state == S_MEMRD) begin
                mr_cyc++;
                if (!memread || !iord) mr_bad++;
            end
            if (retire) begin
                done = 1'b1;
                cycles = k + 1;
                check("lw_stall instret", 32'(instret), 32'(exp_instret));
                exp_instret++;
            end
            @(negedge clk);
        end
        mem_ready = 1'b1;
        check("lw_stall retired", 32'(done), 32'(1));
        check("lw_stall cycles", cycles, 9);
        check("lw_stall irwrite pulses", irw, 1);
        check("lw_stall memrd cycles", mr_cyc, 3);
        check("lw_stall memread held", mr_bad, 0);
    endtask

    task automatic go_halt(input string name, input logic [5:0] o, input logic [5:0] f);
        int bad = 0;
        op = o; funct = f; mem_ready = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        check({name, " state"}, 32'(state), 32'(S_HALT));
        check({name, " halted"}, 32'(halted), 32'(1));
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            op = 6'($urandom); funct = 6'($urandom); zero = 1'($urandom);
            #1;
            if ({memread, memwrite, irwrite, regwrite, pcen, retire} != 6'd0 ||
                state != S_HALT || !halted) bad++;
        end
        check({name, " absorbing quiet"}, bad, 0);
        #1 reset = 1'b1;
        #1;
        check({name, " reset state"}, 32'(state), 32'(S_FETCH));
        check({name, " reset halted"}, 32'(halted), 32'(0));
        check({name, " reset instret"}, 32'(instret), 32'(0));
        check({name, " reset memread"}, 32'(memread), 32'(0));
        @(negedge clk);
        reset = 1'b0;
        exp_instret = '0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; op = 6'd0; funct = 6'd0; zero = 1'b0; mem_ready = 1'b1;
        exp_instret = '0;

        //             name     op     funct  z  n  s2  s3 s4  alu2     pe ps   rw rd  m2r falu     ext    mw
        vecs.push_back(mk("add",   6'h00, 6'h20, 0, 4, 6,  7, 0, ALU_ADD,  0, 2'd0, 1, 2'd1, 2'd0, ALU_ADD, 2'b00, 0));
        vecs.push_back(mk("subu",  6'h00, 6'h23, 0, 4, 6,  7, 0, ALU_SUB,  0, 2'd0, 1, 2'd1, 2'd0, ALU_ADD, 2'b00, 0));
        vecs.push_back(mk("and",   6'h00, 6'h24, 0, 4, 6,  7, 0, ALU_AND,  0, 2'd0, 1, 2'd1, 2'd0, ALU_ADD, 2'b00, 0));
        vecs.push_back(mk("or",    6'h00, 6'h25, 0, 4, 6,  7, 0, ALU_OR,   0, 2'd0, 1, 2'd1, 2'd0, ALU_ADD, 2'b00, 0));
        vecs.push_back(mk("slt",   6'h00, 6'h2a, 0, 4, 6,  7, 0, ALU_SLT,  0, 2'd0, 1, 2'd1, 2'd0, ALU_ADD, 2'b00, 0));
        vecs.push_back(mk("sltu",  6'h00, 6'h2b, 0, 4, 6,  7, 0, ALU_SLTU, 0, 2'd0, 1, 2'd1, 2'd0, ALU_ADD, 2'b00, 0));
        vecs.push_back(mk("addi",  6'h08, 6'h00, 0, 4, 8,  9, 0, ALU_ADD,  0, 2'd0, 1, 2'd0, 2'd0, ALU_ADD, 2'b10, 0));
        vecs.push_back(mk("addiu", 6'h09, 6'h00, 0, 4, 8,  9, 0, ALU_ADD,  0, 2'd0, 1, 2'd0, 2'd0, ALU_ADD, 2'b10, 0));
        vecs.push_back(mk("slti",  6'h0a, 6'h00, 0, 4, 8,  9, 0, ALU_SLT,  0, 2'd0, 1, 2'd0, 2'd0, ALU_SLT, 2'b10, 0));
        vecs.push_back(mk("sltiu", 6'h0b, 6'h00, 0, 4, 8,  9, 0, ALU_SLTU, 0, 2'd0, 1, 2'd0, 2'd0, ALU_SLTU, 2'b10, 0));
        vecs.push_back(mk("ori",   6'h0d, 6'h00, 0, 4, 8,  9, 0, ALU_OR,   0, 2'd0, 1, 2'd0, 2'd0, ALU_OR,  2'b00, 0));
        vecs.push_back(mk("lui",   6'h0f, 6'h00, 0, 4, 8,  9, 0, ALU_ADD,  0, 2'd0, 1, 2'd0, 2'd0, ALU_ADD, 2'b01, 0));
        vecs.push_back(mk("lw",    6'h23, 6'h00, 0, 5, 2,  3, 4, ALU_ADD,  0, 2'd0, 1, 2'd0, 2'd1, ALU_ADD, 2'b00, 0));
        vecs.push_back(mk("sw",    6'h2b, 6'h00, 0, 4, 2,  5, 0, ALU_ADD,  0, 2'd0, 0, 2'd0, 2'd0, ALU_ADD, 2'b00, 1));
        vecs.push_back(mk("beq_z1", 6'h04, 6'h00, 1, 3, 10, 0, 0, ALU_SUB, 1, 2'd1, 0, 2'd0, 2'd0, ALU_SUB, 2'b00, 0));
        vecs.push_back(mk("beq_z0", 6'h04, 6'h00, 0, 3, 10, 0, 0, ALU_SUB, 0, 2'd1, 0, 2'd0, 2'd0, ALU_SUB, 2'b00, 0));
        vecs.push_back(mk("bne_z1", 6'h05, 6'h00, 1, 3, 10, 0, 0, ALU_SUB, 0, 2'd1, 0, 2'd0, 2'd0, ALU_SUB, 2'b00, 0));
        vecs.push_back(mk("bne_z0", 6'h05, 6'h00, 0, 3, 10, 0, 0, ALU_SUB, 1, 2'd1, 0, 2'd0, 2'd0, ALU_SUB, 2'b00, 0));
        j_vec = mk("j", 6'h02, 6'h00, 0, 3, 11, 0, 0, ALU_ADD, 1, 2'd2, 0, 2'd0, 2'd0, ALU_ADD, 2'b00, 0);
        vecs.push_back(j_vec);
        vecs.push_back(mk("jal",   6'h03, 6'h00, 0, 3, 12, 0, 0, ALU_ADD, 1, 2'd2, 1, 2'd2, 2'd2, ALU_ADD, 2'b00, 0));
        vecs.push_back(mk("jr",    6'h00, 6'h08, 0, 3, 13, 0, 0, ALU_ADD, 1, 2'd3, 0, 2'd0, 2'd0, ALU_ADD, 2'b00, 0));

        @(negedge clk);
        #1;
        check("reset state", 32'(state), 32'(S_FETCH));
        check("reset forced strobes", 32'({memread, memwrite, irwrite, regwrite, pcen, retire}), 32'(0));
        check("reset fetch selects", 32'({iord, alusrca, alusrcb, alucontrol, pcsrc}), 32'(10'b0001001000));
        check("reset instret", 32'(instret), 32'(0));
        check("reset halted", 32'(halted), 32'(0));
        @(negedge clk);
        reset = 1'b0;

        foreach (vecs[i]) run_vec(vecs[i]);
        check("table instret wrapped", 32'(instret), 32'(exp_instret));

        lw_stall();

        go_halt("illegal_op", 6'h3f, 6'h00);
        go_halt("illegal_funct", 6'h00, 6'h3f);

        // Reset arrives mid-cycle while a store is held in MEMWR by mem_ready=0.
        op = OP_SW; funct = 6'd0; mem_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            if (k == 3) mem_ready = 1'b0;
            #1;
            if (k == 3) begin
                check("memwr state", 32'(state), 32'(S_MEMWR));
                check("memwr memwrite held", 32'(memwrite), 32'(1));
                #1 reset = 1'b1;
                #1;
                check("async reset memwrite drop", 32'(memwrite), 32'(0));
                check("async reset state", 32'(state), 32'(S_FETCH));
            end
            @(negedge clk);
        end
        reset = 1'b0;
        mem_ready = 1'b1;
        exp_instret = '0;

        for (int i = 0; i < 16; i++) run_vec(j_vec);
        check("instret wrap to zero", 32'(instret), 32'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
